// File: rtl/fetch_pkg.sv
// Shared fetch types: FSM state encoding, queue entry layout and the default reset PC.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DROP
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Sequential fetch step; wraps naturally at 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instr, pc} entries with flush; head is readable with zero latency.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     ram [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB separates full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr == {~rd_ptr[PTR_W], rd_ptr[PTR_W-1:0]});
  assign rdata = ram[rd_ptr[PTR_W-1:0]];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) ram[wr_ptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch: one-outstanding memory read FSM feeding a prefetch queue toward decode.
// Define FETCH_MISALIGN_TRAP_EN to flag and ignore redirects with a misaligned target.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        InstrD_valid,
  input  logic        InstrD_ready,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);

  fetch_state_e state;
  logic [31:0]  fetch_pc;
  logic         redir;
  logic [31:0]  target;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  fetch_entry_t wdata;
  fetch_entry_t head;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;

  // A misaligned redirect is reported and otherwise behaves as if it never came.
  assign misaligned = PCSrcE && (PCTargetE[1:0] != 2'b00);
  assign redir      = PCSrcE && !misaligned;
  assign target     = PCTargetE;

  always_ff @(posedge clk) begin
    if (rst) fetch_misalign <= 1'b0;
    else     fetch_misalign <= misaligned;
  end
`else
  assign redir  = PCSrcE;
  assign target = PCTargetE & 32'hFFFF_FFFC;
`endif

  // Data is only accepted in WAIT, so stale responses from before a reset or redirect are dropped.
  assign push  = (state == ST_WAIT) && mem_rvalid && !redir;
  assign pop   = InstrD_valid && InstrD_ready && !redir;
  assign wdata = '{instr: mem_rdata, pc: fetch_pc};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .wdata (wdata),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign InstrD_valid = !empty;
  assign InstrD       = head.instr;
  assign PCD          = head.pc;
  assign PCPlus4D     = pc_next(head.pc);
  assign mem_addr     = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Nothing outstanding here, so room in the queue is the only gate.
          if (redir) fetch_pc <= target;
          if (redir || !full) begin
            state   <= ST_REQ;
            mem_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (redir) fetch_pc <= target;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= redir ? ST_DROP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redir) begin
            fetch_pc <= target;
            state    <= mem_rvalid ? ST_IDLE : ST_DROP;
          end else if (mem_rvalid) begin
            fetch_pc <= pc_next(fetch_pc);
            state    <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (redir) fetch_pc <= target;
          if (mem_rvalid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised bench for instr_fetch_queue against a queue-level reference model, plus directed scenarios.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        InstrD_valid, InstrD_ready;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        w_req, w_gnt, w_rvalid, w_vld;
  logic [31:0] w_addr, w_rdata, w_instr, w_pcd, w_pc4;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
  logic        w_mis;
`endif

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .InstrD_valid(InstrD_valid), .InstrD_ready(InstrD_ready), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .mem_req(w_req), .mem_addr(w_addr), .mem_gnt(w_gnt),
    .mem_rvalid(w_rvalid), .mem_rdata(w_rdata), .PCSrcE(1'b0), .PCTargetE(32'h0),
    .InstrD_valid(w_vld), .InstrD_ready(1'b1), .InstrD(w_instr), .PCD(w_pcd),
    .PCPlus4D(w_pc4)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_misalign(w_mis)
`endif
  );

  int          n_chk, n_fail;
  // reference model
  ent_t        q[$];
  logic [31:0] m_pc, m_oaddr;
  bit          m_out, m_live, exp_mis;
  // bench memory
  bit          mo_valid;
  int          mo_delay;
  logic [31:0] mo_addr;
  // knobs
  int          k_gnt, k_rdy, k_redir, k_dly, f_rdy;
  bit          f_redir;
  logic [31:0] f_tgt;
  int          grants;
  bit          gnt_seen, rst_d, w_out, ok;
  logic [31:0] last_gaddr, w_oaddr, exp_pcd;
  logic [31:0] w_addrs[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h0000_0013 ^ (a << 7);
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%08h exp=%08h", tag, act, exp);
    end
  endtask

  // One clock: drive after the edge, check and advance the model at negedge.
  task automatic step();
    bit          redir;
    logic [31:0] tgt;
    mem_gnt    = mem_req && !mo_valid && !rst && ($urandom_range(0, 99) < k_gnt);
    mem_rvalid = mo_valid && (mo_delay == 0);
    mem_rdata  = mem_rvalid ? instr_of(mo_addr) : $urandom();
    if (mo_valid && mo_delay > 0) mo_delay--;
    InstrD_ready = (f_rdy >= 0) ? (f_rdy != 0) : ($urandom_range(0, 99) < k_rdy);
    if (f_redir) begin
      PCSrcE = 1'b1; PCTargetE = f_tgt; f_redir = 0;
    end else begin
      PCSrcE    = ($urandom_range(0, 99) < k_redir);
      PCTargetE = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom();
    end
    w_gnt = w_req && !rst; w_rvalid = w_out; w_rdata = instr_of(w_oaddr);
    @(negedge clk);
    if (rst) begin
      if (rst_d) begin
        chk("rst_req", mem_req, 0);
        chk("rst_vld", InstrD_valid, 0);
      end
      q.delete(); m_pc = 32'h0; m_out = 0; m_live = 0; exp_mis = 0;
      grants = 0; gnt_seen = 0; w_out = 0;
    end else begin
      chk("vld", InstrD_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("instr", InstrD, q[0].instr);
        chk("pcd", PCD, q[0].pc);
        chk("pc4", PCPlus4D, q[0].pc + 32'd4);
      end
      if (mem_req) begin
        chk("addr", mem_addr, m_pc);
        chk("one_out", m_out, 0);
        chk("room", (q.size() + m_out) < DEPTH, 1);
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("mis", fetch_misalign, exp_mis);
      redir   = PCSrcE && (PCTargetE[1:0] == 2'b00);
      tgt     = PCTargetE;
      exp_mis = PCSrcE && (PCTargetE[1:0] != 2'b00);
`else
      redir = PCSrcE;
      tgt   = {PCTargetE[31:2], 2'b00};
`endif
      if (q.size() != 0 && InstrD_ready && !redir) void'(q.pop_front());
      if (mem_rvalid && m_out) begin
        if (m_live && !redir) begin
          q.push_back('{instr_of(m_oaddr), m_oaddr});
          m_pc = m_oaddr + 32'd4;
        end
        m_out = 0;
      end
      if (mem_req && mem_gnt) begin
        m_out = 1; m_live = !redir; m_oaddr = m_pc;
      end
      if (redir) begin
        q.delete(); m_pc = tgt; m_live = 0;
      end
    end
    if (mem_rvalid) mo_valid = 0;
    if (mem_req && mem_gnt && !rst) begin
      mo_valid = 1; mo_addr = mem_addr; mo_delay = $urandom_range(0, k_dly);
      grants++; last_gaddr = mem_addr; gnt_seen = 1;
    end
    if (w_rvalid) w_out = 0;
    if (w_req && w_gnt && !rst) begin
      w_out = 1; w_oaddr = w_addr;
      if (w_addrs.size() < 3) w_addrs.push_back(w_addr);
    end
    rst_d = rst;
    @(posedge clk); #1;
  endtask

  // A read still in flight at reset comes back as a stale response shortly after release.
  task automatic do_reset(input int n);
    if (mo_valid) mo_delay = n + 1;
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; grants = 0; gnt_seen = 0; rst_d = 0;
    mo_valid = 0; mo_delay = 0; mo_addr = 0; w_out = 0; w_oaddr = 0;
    m_pc = 0; m_oaddr = 0; m_out = 0; m_live = 0; exp_mis = 0; last_gaddr = 0;
    rst = 1; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; PCSrcE = 0; PCTargetE = 0;
    InstrD_ready = 0; w_gnt = 0; w_rvalid = 0; w_rdata = 0;
    k_gnt = 100; k_rdy = 0; k_redir = 0; k_dly = 0; f_rdy = 0; f_redir = 0; f_tgt = 0;
    @(posedge clk); #1;
    do_reset(3);

    // first fetch: grant at once, data one cycle later, visible the cycle after push
    repeat (4) step();
    chk("first_vld", InstrD_valid, 1);
    chk("first_instr", InstrD, 32'h0000_0013);
    chk("first_pcd", PCD, 32'h0);
    chk("first_pc4", PCPlus4D, 32'h4);
    chk("first_addr", last_gaddr, 32'h0);

    // fill and stall with decode blocked
    repeat (30) step();
    chk("fill_grants", grants, DEPTH);
    chk("stall_req", mem_req, 0);
    f_rdy = 1; k_gnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_seq", PCD, i * 4);
      step();
    end
    chk("drained", InstrD_valid, 0);

    // redirect while a read is in flight
    f_rdy = 0; k_gnt = 100; k_dly = 3;
    for (int i = 0; i < 60 && !(q.size() != 0 && mo_valid && mo_delay > 0); i++) step();
    ok = (q.size() != 0 && mo_valid && mo_delay > 0);
    chk("wait_setup", ok, 1);
    f_redir = 1; f_tgt = 32'h100; step();
    chk("redir_empty", InstrD_valid, 0);
    gnt_seen = 0;
    for (int i = 0; i < 20 && !gnt_seen; i++) step();
    chk("redir_addr", last_gaddr, 32'h100);
    for (int i = 0; i < 20 && !InstrD_valid; i++) step();
    chk("redir_pcd", PCD, 32'h100);

    // redirect coincident with returning data and a pop
    k_dly = 1;
    for (int i = 0; i < 60 && !(q.size() != 0 && mo_valid && mo_delay == 0); i++) step();
    ok = (q.size() != 0 && mo_valid && mo_delay == 0);
    chk("coin_setup", ok, 1);
    f_rdy = 1; f_redir = 1; f_tgt = 32'h200; step();
    chk("coin_empty", InstrD_valid, 0);
    f_rdy = 0; gnt_seen = 0;
    for (int i = 0; i < 20 && !gnt_seen; i++) step();
    chk("coin_addr", last_gaddr, 32'h200);

`ifdef FETCH_MISALIGN_TRAP_EN
    k_dly = 0;
    for (int i = 0; i < 40 && q.size() < 2; i++) step();
    exp_pcd = (q.size() != 0) ? q[0].pc : 32'hDEAD_BEEF;
    f_redir = 1; f_tgt = 32'h102; step();
    chk("mis_pulse", fetch_misalign, 1);
    chk("mis_keep", InstrD_valid, 1);
    chk("mis_pcd", PCD, exp_pcd);
    step();
    chk("mis_clear", fetch_misalign, 0);
`endif

    // RESET_PC at the top of the address space wraps on the second fetch
    chk("wrap_n", w_addrs.size(), 3);
    if (w_addrs.size() >= 3) begin
      chk("wrap_a0", w_addrs[0], 32'hFFFF_FFFC);
      chk("wrap_a1", w_addrs[1], 32'h0);
      chk("wrap_a2", w_addrs[2], 32'h4);
    end

    // random traffic with periodic resets mid-read
    k_gnt = 70; k_rdy = 60; k_redir = 3; k_dly = 3; f_rdy = -1;
    for (int r = 0; r < 4; r++) begin
      repeat (600) step();
      do_reset(2);
    end
    repeat (200) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
